// File: rtl/ctrl_decode_stage.sv
// Registered ID-stage decoder: RV32I (+ optional M, CSR) into an ID/EX control bundle,
// with a valid/ready handshake and a trap FSM for interrupts and synchronous exceptions.
module ctrl_decode_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4,
    parameter int EN_M    = 0,
    parameter int EN_CSR  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ex_ready,
    output logic [XLEN-1:0]    o_pc,
    output logic               o_rd_wren,
    output logic               o_br_un,
    output logic               o_opa_sel,
    output logic [1:0]         o_opb_sel,
    output logic [3:0]         o_alu_op,
    output logic               o_lsu_wren,
    output logic [1:0]         o_wb_sel,
    output logic [2:0]         o_ld_en,
    output logic               o_csr_en,
    output logic [2:0]         o_csr_op,
    output logic               o_md_en,
    output logic               o_mret,
    input  logic               i_mie,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic               o_trap_req,
    output logic [4:0]         o_trap_cause,
    output logic [XLEN-1:0]    o_trap_pc,
    input  logic               i_trap_ack
);
    typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_DRAIN} state_t;

    typedef struct packed {
        logic       rd_wren;
        logic       br_un;
        logic       opa_sel;
        logic [1:0] opb_sel;
        logic [3:0] alu_op;
        logic       lsu_wren;
        logic [1:0] wb_sel;
        logic [2:0] ld_en;
        logic       csr_en;
        logic [2:0] csr_op;
        logic       md_en;
        logic       mret;
    } ctl_t;

    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_LD    = 7'b0000011;
    localparam logic [6:0]  OP_ST    = 7'b0100011;
    localparam logic [6:0]  OP_BR    = 7'b1100011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_SYS   = 7'b1110011;
    localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INS_MRET   = 32'h3020_0073;
    localparam logic [3:0]  ALU_ADD  = 4'b0000;
    localparam logic [3:0]  ALU_PASS = 4'b1111;

    state_t        r_state, w_state_nxt;
    ctl_t          r_ctl, w_ctl;
    logic          r_valid;
    logic [XLEN-1:0] r_pc, r_trap_pc;
    logic [4:0]    r_cause, w_cause;
    logic          w_legal, w_ecall, w_ebreak;
    logic          w_irq_pend, w_take, w_trap, w_issue;
    logic [3:0]    w_irq_idx;
    logic [6:0]    w_opc, w_f7;
    logic [2:0]    w_f3;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    always_comb begin
        w_ctl    = '0;
        w_legal  = 1'b0;
        w_ecall  = 1'b0;
        w_ebreak = 1'b0;
        case (w_opc)
            OP_R: begin
                w_ctl.rd_wren = 1'b1;
                w_ctl.wb_sel  = 2'b01;
                w_ctl.alu_op  = {w_f7[5], w_f3};
                if (w_f7 == 7'b0000000 ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_legal = 1'b1;
                end else if (EN_M != 0 && w_f7 == 7'b0000001) begin
                    w_legal      = 1'b1;
                    w_ctl.md_en  = 1'b1;
                end
            end
            OP_I: begin
                w_ctl.rd_wren = 1'b1;
                w_ctl.opb_sel = 2'b01;
                w_ctl.wb_sel  = 2'b01;
                if (w_f3 == 3'b001) begin
                    w_legal      = (w_f7 == 7'b0000000);
                    w_ctl.alu_op = {1'b0, w_f3};
                end else if (w_f3 == 3'b101) begin
                    w_legal      = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    w_ctl.alu_op = {w_f7[5], w_f3};
                end else begin
                    w_legal      = 1'b1;
                    w_ctl.alu_op = {1'b0, w_f3};
                end
            end
            OP_LD: begin
                w_legal       = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_ctl.rd_wren = 1'b1;
                w_ctl.opb_sel = 2'b01;
                w_ctl.alu_op  = ALU_ADD;
                w_ctl.ld_en   = w_f3;
            end
            OP_ST: begin
                w_legal        = (w_f3[2] == 1'b0) && (w_f3 != 3'b011);
                w_ctl.lsu_wren = 1'b1;
                w_ctl.opb_sel  = 2'b01;
                w_ctl.ld_en    = w_f3;
            end
            OP_BR: begin
                w_legal       = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_ctl.br_un   = ~w_f3[1];
                w_ctl.opa_sel = 1'b1;
                w_ctl.opb_sel = 2'b01;
            end
            OP_JAL, OP_JALR: begin
                w_legal       = (w_opc == OP_JAL) || (w_f3 == 3'b000);
                w_ctl.rd_wren = 1'b1;
                w_ctl.opa_sel = (w_opc == OP_JAL);
                w_ctl.opb_sel = 2'b01;
                w_ctl.wb_sel  = 2'b10;
            end
            OP_LUI, OP_AUIPC: begin
                w_legal       = 1'b1;
                w_ctl.rd_wren = 1'b1;
                w_ctl.opa_sel = (w_opc == OP_AUIPC);
                w_ctl.opb_sel = 2'b01;
                w_ctl.alu_op  = (w_opc == OP_LUI) ? ALU_PASS : ALU_ADD;
                w_ctl.wb_sel  = 2'b01;
            end
            OP_SYS: begin
                if (EN_CSR != 0) begin
                    // ecall/ebreak are "legal" encodings that still trap below
                    if (w_f3 == 3'b000) begin
                        w_ecall    = (i_instr == INS_ECALL);
                        w_ebreak   = (i_instr == INS_EBREAK);
                        w_ctl.mret = (i_instr == INS_MRET);
                        w_legal    = w_ecall || w_ebreak || w_ctl.mret;
                    end else if (w_f3 != 3'b100) begin
                        w_legal       = 1'b1;
                        w_ctl.rd_wren = 1'b1;
                        w_ctl.opb_sel = 2'b10;
                        w_ctl.alu_op  = ALU_PASS;
                        w_ctl.wb_sel  = 2'b01;
                        w_ctl.csr_en  = 1'b1;
                        w_ctl.csr_op  = w_f3;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Lowest-numbered pending line wins
    always_comb begin
        w_irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_irq[i]) w_irq_idx = 4'(i);
        end
    end

    assign w_irq_pend = i_mie && (|i_irq);
    assign w_take     = i_valid && o_ready && !i_flush;
    assign w_trap     = w_take && (w_irq_pend || !w_legal || w_ecall || w_ebreak);
    assign w_issue    = w_take && !w_trap;

    always_comb begin
        if (w_irq_pend)    w_cause = {1'b1, w_irq_idx};
        else if (!w_legal) w_cause = 5'b00010;
        else if (w_ecall)  w_cause = 5'b01011;
        else               w_cause = 5'b00011;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_trap_req  = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_ready = !r_valid || i_ex_ready;
                if (w_trap) w_state_nxt = ST_TRAP;
            end
            ST_TRAP: begin
                o_trap_req = 1'b1;
                if (i_trap_ack) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // An accepted instruction replaces the slot in the same cycle the old bundle leaves
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_ctl     <= '0;
            r_pc      <= '0;
            r_cause   <= '0;
            r_trap_pc <= '0;
        end else begin
            if (r_state == ST_RUN && i_flush) r_valid <= 1'b0;
            else if (w_issue)                 r_valid <= 1'b1;
            else if (i_ex_ready)              r_valid <= 1'b0;
            if (w_issue) begin
                r_ctl <= w_ctl;
                r_pc  <= i_pc;
            end
            if (w_trap) begin
                r_cause   <= w_cause;
                r_trap_pc <= i_pc;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_pc         = r_pc;
    assign o_rd_wren    = r_ctl.rd_wren;
    assign o_br_un      = r_ctl.br_un;
    assign o_opa_sel    = r_ctl.opa_sel;
    assign o_opb_sel    = r_ctl.opb_sel;
    assign o_alu_op     = r_ctl.alu_op;
    assign o_lsu_wren   = r_ctl.lsu_wren;
    assign o_wb_sel     = r_ctl.wb_sel;
    assign o_ld_en      = r_ctl.ld_en;
    assign o_csr_en     = r_ctl.csr_en;
    assign o_csr_op     = r_ctl.csr_op;
    assign o_md_en      = r_ctl.md_en;
    assign o_mret       = r_ctl.mret;
    assign o_trap_cause = r_cause;
    assign o_trap_pc    = r_trap_pc;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: decode table, hand-written multi-cycle sequences,
// then randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ctrl_decode_stage;
    typedef struct packed {
        logic       rd_wren;
        logic       br_un;
        logic       opa_sel;
        logic [1:0] opb_sel;
        logic [3:0] alu_op;
        logic       lsu_wren;
        logic [1:0] wb_sel;
        logic [2:0] ld_en;
        logic       csr_en;
        logic [2:0] csr_op;
        logic       md_en;
        logic       mret;
    } ctl_t;

    typedef struct {
        logic [31:0] instr;
        bit          trap;
        logic [4:0]  cause;
        ctl_t        ctl;
    } vec_t;

    localparam int K_OK = 0, K_ILL = 1, K_ECALL = 2, K_EBREAK = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld = 0, fl = 0, exr = 0, mie = 0, ack = 0;
    logic [31:0] ins = 0, pc = 0;
    logic [3:0]  irq = 0;
    logic        o_ready, o_valid, o_rd_wren, o_br_un, o_opa_sel, o_lsu_wren;
    logic        o_csr_en, o_md_en, o_mret, o_trap_req;
    logic [1:0]  o_opb_sel, o_wb_sel;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_ld_en, o_csr_op;
    logic [4:0]  o_trap_cause;
    logic [31:0] o_pc, o_trap_pc;
    ctl_t        act;
    assign act = {o_rd_wren, o_br_un, o_opa_sel, o_opb_sel, o_alu_op, o_lsu_wren,
                  o_wb_sel, o_ld_en, o_csr_en, o_csr_op, o_md_en, o_mret};

    ctrl_decode_stage #(.XLEN(32), .NUM_IRQ(4), .EN_M(0), .EN_CSR(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(o_ready),
        .i_instr(ins), .i_pc(pc), .i_flush(fl), .o_valid(o_valid),
        .i_ex_ready(exr), .o_pc(o_pc), .o_rd_wren(o_rd_wren), .o_br_un(o_br_un),
        .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op),
        .o_lsu_wren(o_lsu_wren), .o_wb_sel(o_wb_sel), .o_ld_en(o_ld_en),
        .o_csr_en(o_csr_en), .o_csr_op(o_csr_op), .o_md_en(o_md_en), .o_mret(o_mret),
        .i_mie(mie), .i_irq(irq), .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause),
        .o_trap_pc(o_trap_pc), .i_trap_ack(ack)
    );

    // Second instance with the M extension enabled
    logic        m_vld = 0;
    logic [31:0] m_ins = 0;
    logic        m_ready, m_valid, m_rd_wren, m_br_un, m_opa_sel, m_lsu_wren;
    logic        m_csr_en, m_md_en, m_mret, m_trap_req;
    logic [1:0]  m_opb_sel, m_wb_sel;
    logic [3:0]  m_alu_op;
    logic [2:0]  m_ld_en, m_csr_op;
    logic [4:0]  m_trap_cause;
    logic [31:0] m_pc, m_trap_pc;
    ctl_t        m_act;
    assign m_act = {m_rd_wren, m_br_un, m_opa_sel, m_opb_sel, m_alu_op, m_lsu_wren,
                    m_wb_sel, m_ld_en, m_csr_en, m_csr_op, m_md_en, m_mret};

    ctrl_decode_stage #(.XLEN(32), .NUM_IRQ(4), .EN_M(1), .EN_CSR(1)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(m_vld), .o_ready(m_ready),
        .i_instr(m_ins), .i_pc(32'h200), .i_flush(1'b0), .o_valid(m_valid),
        .i_ex_ready(1'b1), .o_pc(m_pc), .o_rd_wren(m_rd_wren), .o_br_un(m_br_un),
        .o_opa_sel(m_opa_sel), .o_opb_sel(m_opb_sel), .o_alu_op(m_alu_op),
        .o_lsu_wren(m_lsu_wren), .o_wb_sel(m_wb_sel), .o_ld_en(m_ld_en),
        .o_csr_en(m_csr_en), .o_csr_op(m_csr_op), .o_md_en(m_md_en), .o_mret(m_mret),
        .i_mie(1'b0), .i_irq(4'b0000), .o_trap_req(m_trap_req), .o_trap_cause(m_trap_cause),
        .o_trap_pc(m_trap_pc), .i_trap_ack(1'b0)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t mk(input int rd, input int brun, input int opa, input int opb,
                                input int alu, input int lsu, input int wb, input int ld,
                                input int csr, input int csrop, input int md, input int mret);
        ctl_t c;
        c.rd_wren = 1'(rd);   c.br_un = 1'(brun);   c.opa_sel = 1'(opa);
        c.opb_sel = 2'(opb);  c.alu_op = 4'(alu);   c.lsu_wren = 1'(lsu);
        c.wb_sel = 2'(wb);    c.ld_en = 3'(ld);     c.csr_en = 1'(csr);
        c.csr_op = 3'(csrop); c.md_en = 1'(md);     c.mret = 1'(mret);
        return c;
    endfunction

    vec_t tbl[$];
    task automatic add(input logic [31:0] i, input bit t, input int cause, input ctl_t c);
        vec_t v;
        v.instr = i; v.trap = t; v.cause = 5'(cause); v.ctl = c;
        tbl.push_back(v);
    endtask

    // Reference: classify the word into an instruction class, then list that class's controls
    function automatic void model_decode(input logic [31:0] w, input bit en_m,
                                         output ctl_t c, output int kind);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        c = '0;
        kind = K_ILL;
        if (w == 32'h0000_0073) begin kind = K_ECALL;  return; end
        if (w == 32'h0010_0073) begin kind = K_EBREAK; return; end
        if (w == 32'h3020_0073) begin kind = K_OK; c.mret = 1'b1; return; end
        case (op)
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (en_m && f7 == 1)) begin
                kind = K_OK;
                c = mk(1, 0, 0, 0, {f7[5], f3}, 0, 1, 0, 0, 0, int'(f7 == 1), 0);
            end
            7'h13: if ((f3 != 1 && f3 != 5) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20))) begin
                kind = K_OK;
                c = mk(1, 0, 0, 1, (f3 == 5) ? {f7[5], f3} : {1'b0, f3}, 0, 1, 0, 0, 0, 0, 0);
            end
            7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
                kind = K_OK; c = mk(1, 0, 0, 1, 0, 0, 0, f3, 0, 0, 0, 0);
            end
            7'h23: if (f3 <= 2) begin
                kind = K_OK; c = mk(0, 0, 0, 1, 0, 1, 0, f3, 0, 0, 0, 0);
            end
            7'h63: if (f3 != 2 && f3 != 3) begin
                kind = K_OK; c = mk(0, int'(f3 < 6), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            7'h6F: begin kind = K_OK; c = mk(1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0); end
            7'h67: if (f3 == 0) begin kind = K_OK; c = mk(1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0); end
            7'h37: begin kind = K_OK; c = mk(1, 0, 0, 1, 15, 0, 1, 0, 0, 0, 0, 0); end
            7'h17: begin kind = K_OK; c = mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0); end
            7'h73: if (f3 != 0 && f3 != 4) begin
                kind = K_OK; c = mk(1, 0, 0, 2, 15, 0, 1, 0, 1, f3, 0, 0);
            end
            default: kind = K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        case ($urandom % 8)
            0: return w;
            1: case ($urandom % 3)
                   0: return 32'h0000_0073;
                   1: return 32'h0010_0073;
                   default: return 32'h3020_0073;
               endcase
            default: begin
                w[6:0] = ops[$urandom % 10];
                if ($urandom % 2 == 1) w[31:25] = ($urandom % 2 == 1) ? 7'h00 : 7'h20;
                return w;
            end
        endcase
    endfunction

    // Transaction-level model state: mode 0=issuing, 1=trap requested, 2=redirect cycle
    int          ms = 0;
    bit          mv = 0;
    ctl_t        mc = '0;
    logic [31:0] mpc = 0, mtpc = 0;
    logic [4:0]  mcause = 0;

    task automatic model_edge();
        int   old = ms;
        bit   rdy = (ms == 0) && (!mv || exr);
        bit   take = vld && rdy && !fl;
        bit   irq_on = mie && (irq != 0);
        ctl_t c;
        int   kind;
        if (old == 0 && fl) mv = 0;
        else if (take) begin
            model_decode(ins, 0, c, kind);
            if (irq_on || kind != K_OK) begin
                mv = 0;
                ms = 1;
                mtpc = pc;
                if (irq_on) begin
                    mcause = 5'b10000;
                    for (int i = 3; i >= 0; i--) if (irq[i]) mcause = 5'(16 + i);
                end else if (kind == K_ILL)   mcause = 5'b00010;
                else if (kind == K_ECALL)     mcause = 5'b01011;
                else                          mcause = 5'b00011;
            end else begin
                mv = 1; mc = c; mpc = pc;
            end
        end else if (exr) mv = 0;
        if (old == 1 && ack) ms = 2;
        else if (old == 2)   ms = 0;
    endtask

    initial begin
        add(32'h002081B3, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));    // add
        add(32'h402081B3, 0, 0, mk(1, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0));    // sub
        add(32'h00500093, 0, 0, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));    // addi
        add(32'h4030D093, 0, 0, mk(1, 0, 0, 1, 13, 0, 1, 0, 0, 0, 0, 0));   // srai
        add(32'h40309093, 1, 2, '0);                                          // slli, bad funct7
        add(32'h0040A103, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));    // lw
        add(32'h0020A423, 0, 0, mk(0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0));    // sw
        add(32'h00208463, 0, 0, mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));    // beq
        add(32'h0020E463, 0, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));    // bltu
        add(32'h008000EF, 0, 0, mk(1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0));    // jal
        add(32'h000100E7, 0, 0, mk(1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0));    // jalr
        add(32'h123452B7, 0, 0, mk(1, 0, 0, 1, 15, 0, 1, 0, 0, 0, 0, 0));   // lui
        add(32'h00001297, 0, 0, mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));    // auipc
        add(32'h300110F3, 0, 0, mk(1, 0, 0, 2, 15, 0, 1, 0, 1, 1, 0, 0));   // csrrw
        add(32'h3000F0F3, 0, 0, mk(1, 0, 0, 2, 15, 0, 1, 0, 1, 7, 0, 0));   // csrrci
        add(32'h30200073, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));    // mret
        add(32'h00000073, 1, 11, '0);                                          // ecall
        add(32'h00100073, 1, 3, '0);                                           // ebreak
        add(32'hFFFFFFFF, 1, 2, '0);
        add(32'h022081B3, 1, 2, '0);                                           // mul without M
        add(32'h0000000F, 1, 2, '0);                                           // fence
        add(32'h3000C0F3, 1, 2, '0);                                           // SYSTEM funct3=100
        add(32'h0000B003, 1, 2, '0);                                           // load funct3=011

        #12;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_trap_req", 32'(o_trap_req), 0);
        chk("rst_bundle", 32'(act), 0);
        chk("rst_cause", 32'(o_trap_cause), 0);
        chk("rst_trap_pc", o_trap_pc, 0);
        @(negedge clk); rst_n = 1'b1;
        step();
        exr = 1;

        m_vld = 1; m_ins = 32'h022081B3;
        step(); m_vld = 0;
        chk("m_mul_valid", 32'(m_valid), 1);
        chk("m_mul_trap", 32'(m_trap_req), 0);
        chk("m_mul_bundle", 32'(m_act), 32'(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0) | 21'h2));

        foreach (tbl[k]) begin
            vld = 1; ins = tbl[k].instr; pc = 32'(32'h1000 + k * 4);
            step(); vld = 0;
            if (tbl[k].trap) begin
                chk($sformatf("tbl%0d_valid", k), 32'(o_valid), 0);
                chk($sformatf("tbl%0d_trap_req", k), 32'(o_trap_req), 1);
                chk($sformatf("tbl%0d_cause", k), 32'(o_trap_cause), 32'(tbl[k].cause));
                chk($sformatf("tbl%0d_trap_pc", k), o_trap_pc, pc);
                ack = 1; step(); ack = 0;
                chk($sformatf("tbl%0d_drain_ready", k), 32'(o_ready), 0);
                chk($sformatf("tbl%0d_drain_req", k), 32'(o_trap_req), 0);
                step();
                chk($sformatf("tbl%0d_run_ready", k), 32'(o_ready), 1);
            end else begin
                chk($sformatf("tbl%0d_valid", k), 32'(o_valid), 1);
                chk($sformatf("tbl%0d_bundle", k), 32'(act), 32'(tbl[k].ctl));
                chk($sformatf("tbl%0d_pc", k), o_pc, pc);
                step();
                chk($sformatf("tbl%0d_drained", k), 32'(o_valid), 0);
            end
        end

        // lw held while EX stalls, sw replaces it the cycle EX frees up
        exr = 0; vld = 1; ins = 32'h0040A103;
        step(); ins = 32'h0020A423;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(o_valid), 1);
            chk("hold_ld_en", 32'(o_ld_en), 2);
            chk("hold_lsu", 32'(o_lsu_wren), 0);
            chk("hold_ready", 32'(o_ready), 0);
            step();
        end
        exr = 1; #1;
        chk("hold_release_ready", 32'(o_ready), 1);
        step(); vld = 0;
        chk("sw_valid", 32'(o_valid), 1);
        chk("sw_lsu", 32'(o_lsu_wren), 1);
        chk("sw_ld_en", 32'(o_ld_en), 2);
        step();
        chk("sw_drained", 32'(o_valid), 0);

        mie = 1; irq = 4'b0110; vld = 1; ins = 32'h00500093; pc = 32'h40;
        step(); vld = 0;
        chk("irq_valid", 32'(o_valid), 0);
        chk("irq_trap_req", 32'(o_trap_req), 1);
        chk("irq_cause", 32'(o_trap_cause), 32'h11);
        chk("irq_trap_pc", o_trap_pc, 32'h40);
        irq = 0; step();
        chk("irq_drop_cause", 32'(o_trap_cause), 32'h11);
        chk("irq_drop_req", 32'(o_trap_req), 1);
        ack = 1; step(); ack = 0; step();
        mie = 0; irq = 4'b0110; vld = 1;
        step(); vld = 0;
        chk("nomie_valid", 32'(o_valid), 1);
        chk("nomie_trap_req", 32'(o_trap_req), 0);
        chk("nomie_pc", o_pc, 32'h40);
        mie = 1; irq = 4'b0001;
        step(); step();
        chk("idle_irq_req", 32'(o_trap_req), 0);
        mie = 0; irq = 0;

        vld = 1; fl = 1; ins = 32'hFFFFFFFF;
        step(); vld = 0; fl = 0;
        chk("flush_valid", 32'(o_valid), 0);
        chk("flush_no_trap", 32'(o_trap_req), 0);
        exr = 0; vld = 1; ins = 32'h002081B3;
        step(); vld = 0; fl = 1;
        step(); fl = 0; exr = 1;
        chk("flush_held_valid", 32'(o_valid), 0);
        vld = 1; ins = 32'hFFFFFFFF; pc = 32'h100;
        step(); vld = 0; fl = 1;
        step(); fl = 0;
        chk("flush_in_trap_req", 32'(o_trap_req), 1);
        chk("flush_in_trap_pc", o_trap_pc, 32'h100);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_trap_req", 32'(o_trap_req), 0);
        chk("arst_cause", 32'(o_trap_cause), 0);
        chk("arst_trap_pc", o_trap_pc, 0);
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_bundle", 32'(act), 0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("arst_run_ready", 32'(o_ready), 1);

        ms = 0; mv = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vld = ($urandom % 4) != 0;
            exr = ($urandom % 3) != 0;
            fl  = ($urandom % 16) == 0;
            mie = ($urandom % 2) == 1;
            irq = (($urandom % 6) == 0) ? 4'($urandom) : 4'h0;
            ack = ($urandom % 3) == 0;
            pc  = $urandom & 32'hFFFF_FFFC;
            ins = gen_instr();
            #1;
            chk("rnd_valid", 32'(o_valid), 32'(mv));
            chk("rnd_ready", 32'(o_ready), 32'((ms == 0) && (!mv || exr)));
            chk("rnd_trap_req", 32'(o_trap_req), 32'(ms == 1));
            if (mv) begin
                chk("rnd_bundle", 32'(act), 32'(mc));
                chk("rnd_pc", o_pc, mpc);
            end
            if (ms == 1) begin
                chk("rnd_cause", 32'(o_trap_cause), 32'(mcause));
                chk("rnd_trap_pc", o_trap_pc, mtpc);
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
